// File: rtl/rsa_pkg.sv
// Shared types and timing helpers for the RSA modular-exponentiation unit.
package rsa_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CONV_P,
    CONV_1,
    SQR,
    MUL,
    FROM_MONT,
    FIX,
    DONE
  } state_t;

  // Cycles per Montgomery multiply: one load plus width+2 serial iterations.
  function automatic int mmm_cycles(input int width);
    return width + 3;
  endfunction

endpackage

// File: rtl/rsa_modexp_unit_if.sv
// Request/response bundle between the register front end and the modexp unit.
interface rsa_modexp_unit_if #(
  parameter int WIDTH     = 8,
  parameter int EXP_WIDTH = WIDTH
);
  logic                 ena;
  logic                 clear;
  logic                 start;
  logic [WIDTH-1:0]     P;
  logic [EXP_WIDTH-1:0] E;
  logic [WIDTH-1:0]     M;
  logic [WIDTH-1:0]     R2;
  logic [WIDTH-1:0]     C;
  logic                 busy;
  logic                 done;
  logic                 err;

  modport master (
    output ena, clear, start, P, E, M, R2,
    input  C, busy, done, err
  );

  modport slave (
    input  ena, clear, start, P, E, M, R2,
    output C, busy, done, err
  );
endinterface

// File: rtl/mont_mul_serial.sv
// Bit-serial Montgomery multiplier: R = A*B*2^-(WIDTH+2) mod M, result < 2M.
// done is high during the final iteration; R carries that iteration's result combinationally.
module mont_mul_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH+1:0] A,
  input  logic [WIDTH+1:0] B,
  input  logic [WIDTH-1:0] M,
  output logic [WIDTH+1:0] R,
  output logic             done
);
  localparam int DW = WIDTH + 2;
  localparam int CW = $clog2(DW);

  logic [DW-1:0]    a_sh;
  logic [DW-1:0]    b_reg;
  logic [DW-1:0]    acc;
  logic [WIDTH-1:0] m_reg;
  logic [CW-1:0]    cnt;
  logic             running;
  logic [DW:0]      sum_ab;
  logic [DW:0]      sum_m;

  // acc stays below M+B < 3M, so one extra bit covers the pre-shift sum.
  always_comb begin
    sum_ab = {1'b0, acc} + (a_sh[0] ? {1'b0, b_reg} : '0);
    sum_m  = sum_ab + (sum_ab[0] ? {3'b000, m_reg} : '0);
    R      = sum_m[DW:1];
  end

  assign done = running && (cnt == CW'(DW - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh    <= '0;
      b_reg   <= '0;
      m_reg   <= '0;
      acc     <= '0;
      cnt     <= '0;
      running <= 1'b0;
    end else if (clear) begin
      acc     <= '0;
      cnt     <= '0;
      running <= 1'b0;
    end else if (ena) begin
      if (start) begin
        a_sh    <= A;
        b_reg   <= B;
        m_reg   <= M;
        acc     <= '0;
        cnt     <= '0;
        running <= 1'b1;
      end else if (running) begin
        if (done) begin
          running <= 1'b0;
        end else begin
          acc  <= R;
          a_sh <= a_sh >> 1;
          cnt  <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/rsa_modexp_unit.sv
// C = P^E mod M via one time-shared Montgomery multiplier, left-to-right exponent scan.
//   state     | meaning
//   IDLE      | waiting for start, operands captured on accept
//   CONV_P    | Pb = MMM(P, R2); even M jumps straight to DONE
//   CONV_1    | X = MMM(1, R2); then X = Pb unless E == 0
//   SQR       | X = MMM(X, X) for current bit
//   MUL       | X = MMM(X, Pb) when current bit is set
//   FROM_MONT | X = MMM(X, 1)
//   FIX       | final conditional subtract of M
//   DONE      | publish C/err, pulse done
module rsa_modexp_unit
  import rsa_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int EXP_WIDTH = WIDTH
) (
  input logic               clk,
  input logic               rst,
  rsa_modexp_unit_if.slave  bus
);
  localparam int DW = WIDTH + 2;
  localparam int IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

  state_t               state;
  logic [WIDTH-1:0]     p_reg;
  logic [WIDTH-1:0]     m_reg;
  logic [WIDTH-1:0]     r2_reg;
  logic [EXP_WIDTH-1:0] e_reg;
  logic [IW-1:0]        bit_idx;
  logic [IW-1:0]        lead_idx;
  logic                 e_zero;
  logic                 err_flag;
  logic [DW-1:0]        x;
  logic [DW-1:0]        pb;
  logic                 mm_start;
  logic [DW-1:0]        mm_a;
  logic [DW-1:0]        mm_b;
  logic [DW-1:0]        mm_r;
  logic                 mm_done;
  logic [WIDTH-1:0]     c_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 err_q;

  assign bus.C    = c_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.err  = err_q;

  always_comb begin
    lead_idx = '0;
    for (int i = 0; i < EXP_WIDTH; i++)
      if (bus.E[i]) lead_idx = IW'(i);
  end

  always_comb begin
    mm_a = x;
    mm_b = x;
    case (state)
      CONV_P:    begin mm_a = DW'(p_reg); mm_b = DW'(r2_reg); end
      CONV_1:    begin mm_a = DW'(1);     mm_b = DW'(r2_reg); end
      MUL:       mm_b = pb;
      FROM_MONT: mm_b = DW'(1);
      default:   ;
    endcase
  end

  mont_mul_serial #(.WIDTH(WIDTH)) u_mont (
    .clk   (clk),
    .rst   (rst),
    .ena   (bus.ena),
    .clear (bus.clear),
    .start (mm_start),
    .A     (mm_a),
    .B     (mm_b),
    .M     (m_reg),
    .R     (mm_r),
    .done  (mm_done)
  );

  // Each op's final edge also queues the next load, so ops chain back to back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      p_reg    <= '0;
      m_reg    <= '0;
      r2_reg   <= '0;
      e_reg    <= '0;
      bit_idx  <= '0;
      e_zero   <= 1'b0;
      err_flag <= 1'b0;
      x        <= '0;
      pb       <= '0;
      mm_start <= 1'b0;
      c_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else if (bus.clear) begin
      state    <= IDLE;
      mm_start <= 1'b0;
      c_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else if (bus.ena) begin
      done_q   <= 1'b0;
      mm_start <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          p_reg    <= bus.P;
          e_reg    <= bus.E;
          m_reg    <= bus.M;
          r2_reg   <= bus.R2;
          bit_idx  <= lead_idx;
          e_zero   <= (bus.E == '0);
          err_flag <= ~bus.M[0];
          mm_start <= bus.M[0];
          busy_q   <= 1'b1;
          state    <= CONV_P;
        end
        CONV_P: begin
          if (err_flag) begin
            state <= DONE;
          end else if (mm_done) begin
            pb       <= mm_r;
            mm_start <= 1'b1;
            state    <= CONV_1;
          end
        end
        CONV_1: if (mm_done) begin
          mm_start <= 1'b1;
          if (e_zero) begin
            x     <= mm_r;
            state <= FROM_MONT;
          end else begin
            x <= pb;
            if (bit_idx == '0) begin
              state <= FROM_MONT;
            end else begin
              bit_idx <= bit_idx - IW'(1);
              state   <= SQR;
            end
          end
        end
        SQR: if (mm_done) begin
          x        <= mm_r;
          mm_start <= 1'b1;
          if (e_reg[bit_idx]) begin
            state <= MUL;
          end else if (bit_idx == '0) begin
            state <= FROM_MONT;
          end else begin
            bit_idx <= bit_idx - IW'(1);
            state   <= SQR;
          end
        end
        MUL: if (mm_done) begin
          x        <= mm_r;
          mm_start <= 1'b1;
          if (bit_idx == '0) begin
            state <= FROM_MONT;
          end else begin
            bit_idx <= bit_idx - IW'(1);
            state   <= SQR;
          end
        end
        FROM_MONT: if (mm_done) begin
          x     <= mm_r;
          state <= FIX;
        end
        FIX: begin
          x     <= (x >= DW'(m_reg)) ? (x - DW'(m_reg)) : x;
          state <= DONE;
        end
        DONE: begin
          c_q    <= err_flag ? '0 : x[WIDTH-1:0];
          err_q  <= err_flag;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_modexp_unit.sv
// Scoreboard bench for rsa_modexp_unit: 8-bit directed cases plus a 16-bit random sweep.
module tb_rsa_modexp_unit;

  localparam int S_C    = 0;
  localparam int S_BUSY = 1;
  localparam int S_DONE = 2;
  localparam int S_ERR  = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rsa_modexp_unit_if #(.WIDTH(8),  .EXP_WIDTH(8))  b8  ();
  rsa_modexp_unit_if #(.WIDTH(16), .EXP_WIDTH(16)) b16 ();

  rsa_modexp_unit #(.WIDTH(8), .EXP_WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (b8)
  );

  rsa_modexp_unit #(.WIDTH(16), .EXP_WIDTH(16)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (b16)
  );

  typedef struct {
    longint c;
    longint err;
    longint lat;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic longint modexp(input longint p, input longint e, input longint m);
    longint r;
    longint b;
    longint k;
    r = 1 % m;
    b = p % m;
    k = e;
    while (k > 0) begin
      if (k[0]) r = (r * b) % m;
      b = (b * b) % m;
      k = k >> 1;
    end
    return r;
  endfunction

  function automatic longint lat_of(input int w, input longint e);
    int l;
    int pc;
    l  = 0;
    pc = 0;
    if (e == 0) return longint'(rsa_pkg::mmm_cycles(w) * 3 + 2);
    for (int i = 0; i < 32; i++)
      if (e[i]) begin
        l = i;
        pc++;
      end
    return longint'(rsa_pkg::mmm_cycles(w) * (2 + l + pc - 1 + 1) + 2);
  endfunction

  function automatic longint r2_of(input int w, input longint m);
    longint r;
    r = (longint'(1) << (w + 2)) % m;
    return (r * r) % m;
  endfunction

  function automatic longint sig(input int w, input int k);
    case (k)
      S_C:     return (w == 8) ? longint'(b8.C)    : longint'(b16.C);
      S_BUSY:  return (w == 8) ? longint'(b8.busy) : longint'(b16.busy);
      S_DONE:  return (w == 8) ? longint'(b8.done) : longint'(b16.done);
      default: return (w == 8) ? longint'(b8.err)  : longint'(b16.err);
    endcase
  endfunction

  task automatic drive(input int w, input logic st, input longint p, input longint e,
                       input longint m, input longint r2);
    if (w == 8) begin
      b8.start = st;
      b8.P     = p[7:0];
      b8.E     = e[7:0];
      b8.M     = m[7:0];
      b8.R2    = r2[7:0];
    end else begin
      b16.start = st;
      b16.P     = p[15:0];
      b16.E     = e[15:0];
      b16.M     = m[15:0];
      b16.R2    = r2[15:0];
    end
  endtask

  task automatic set_ena(input int w, input logic v);
    if (w == 8) b8.ena = v;
    else        b16.ena = v;
  endtask

  task automatic run_op(input int w, input longint p, input longint e, input longint m,
                        input bit stall, input bit poke, input string tag);
    exp_t x;
    exp_t got;
    int   cyc;
    int   ovl;
    x.err = (m % 2 == 0) ? 1 : 0;
    x.c   = (x.err != 0) ? 0 : modexp(p, e, m);
    x.lat = (x.err != 0) ? 2 : lat_of(w, e);
    if (stall) x.lat = 2 * x.lat;

    @(negedge clk);
    drive(w, 1'b1, p, e, m, r2_of(w, m));
    set_ena(w, 1'b1);
    sb.push_back(x);
    @(negedge clk);
    drive(w, 1'b0, -1, -1, -1, -1);
    if (stall) set_ena(w, 1'b0);
    check({tag, ".busy"}, sig(w, S_BUSY), 1);

    cyc = 0;
    ovl = 0;
    while (sig(w, S_DONE) == 0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (stall) set_ena(w, (cyc % 2) == 1);
      if (poke)  drive(w, (cyc == 10 || cyc == 30), -1, -1, -1, -1);
      if (sig(w, S_BUSY) != 0 && sig(w, S_DONE) != 0) ovl++;
    end

    got = sb.pop_front();
    check({tag, ".done"},    sig(w, S_DONE), 1);
    check({tag, ".C"},       sig(w, S_C),    got.c);
    check({tag, ".err"},     sig(w, S_ERR),  got.err);
    check({tag, ".lat"},     longint'(cyc),  got.lat);
    check({tag, ".busy_lo"}, sig(w, S_BUSY), 0);
    check({tag, ".overlap"}, longint'(ovl),  0);
    set_ena(w, 1'b1);
    @(negedge clk);
    check({tag, ".pulse"},   sig(w, S_DONE), 0);
  endtask

  initial begin
    int     seen;
    longint m;
    longint p;
    longint e;
    int     ew;

    rst       = 1'b1;
    b8.ena    = 1'b1;
    b8.clear  = 1'b0;
    b16.ena   = 1'b1;
    b16.clear = 1'b0;
    drive(8,  1'b0, 0, 0, 0, 0);
    drive(16, 1'b0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst.C",      sig(8, S_C),     0);
    check("rst.busy",   sig(8, S_BUSY),  0);
    check("rst.done",   sig(8, S_DONE),  0);
    check("rst.err",    sig(8, S_ERR),   0);
    check("rst16.C",    sig(16, S_C),    0);
    check("rst16.busy", sig(16, S_BUSY), 0);

    run_op(8, 5, 3, 13,  0, 0, "p5e3");
    run_op(8, 2, 7, 143, 0, 0, "p2e7");
    run_op(8, 5, 0, 13,  0, 0, "e0");

    // abort mid-run: C is 1 from the E=0 case, so the forced zero is visible
    @(negedge clk);
    drive(8, 1'b1, 5, 3, 13, 9);
    @(negedge clk);
    drive(8, 1'b0, -1, -1, -1, -1);
    repeat (19) @(negedge clk);
    b8.clear = 1'b1;
    @(negedge clk);
    b8.clear = 1'b0;
    check("clr.busy", sig(8, S_BUSY), 0);
    check("clr.C",    sig(8, S_C),    0);
    seen = 0;
    repeat (80) begin
      @(negedge clk);
      if (b8.done) seen++;
    end
    check("clr.no_done", longint'(seen), 0);

    run_op(8, 5, 3, 12, 0, 0, "meven");
    run_op(8, 5, 3, 13, 0, 0, "after_err");
    run_op(8, 5, 3, 13, 0, 1, "poke");
    run_op(8, 5, 3, 13, 1, 0, "stall");
    run_op(8, 0, 9, 1,  0, 0, "m1_8");

    run_op(16, 12345, 16'hFFFF, 65521, 0, 0, "effff");
    run_op(16, 54321, 16'h8000, 65535, 0, 0, "e8000");
    run_op(16, 0,     16'h1234, 1,     0, 0, "m1_16");
    run_op(16, 65534, 16'h0001, 65535, 0, 0, "e1");

    for (int k = 0; k < 150; k++) begin
      m  = longint'($urandom_range(1, 65535) | 1);
      p  = longint'($urandom_range(0, 32'(m - 1)));
      ew = $urandom_range(0, 16);
      e  = longint'($urandom) & ((longint'(1) << ew) - 1);
      run_op(16, p, e, m, 0, 0, $sformatf("rnd%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
